// File: rtl/dram_com_master_pkg.sv
// Shared widths, word types and FSM encodings for the DRAM common-port burst master.
package dram_com_master_pkg;

  localparam int DRAM_AW = 16;
  localparam int DRAM_DW = 16;

  typedef logic [DRAM_AW-1:0] addr_t;
  typedef logic [DRAM_DW-1:0] word_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Reads between issue and FIFO push, one per set bit of the issue shift.
  function automatic logic [1:0] inflight_count(input logic [1:0] issue);
    return {1'b0, issue[0]} + {1'b0, issue[1]};
  endfunction

endpackage

// File: rtl/dram_com_master_if.sv
// Host-side command, write and read-return channels of the common-port burst master.
interface dram_com_master_if;
  import dram_com_master_pkg::*;

  logic  cmd_valid;
  logic  cmd_ready;
  logic  cmd_write;
  addr_t cmd_base;
  addr_t cmd_len;

  logic  wr_valid;
  logic  wr_ready;
  word_t wr_data;

  logic  rd_valid;
  logic  rd_ready;
  word_t rd_data;

  logic  busy;
  logic  done;

  modport master (
    output cmd_valid, cmd_write, cmd_base, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_base, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done
  );

endinterface

// File: rtl/dram_com_master_rd_fifo.sv
// Show-ahead synchronous FIFO holding read words returned from DRAM until the host pops them.
module dram_com_master_rd_fifo
  import dram_com_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  word_t                  push_data_i,
  input  logic                   pop_i,
  output word_t                  head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int PW = $clog2(DEPTH);

  word_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/dram_com_master.sv
// Burst initiator owning the DRAM common port: streams host write words into DRAM
// and returns read words in address order through a credit-limited FIFO.
module dram_com_master
  import dram_com_master_pkg::*;
#(
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  dram_com_master_if.slave  bus,
  output logic              write_en_com,
  output addr_t             addr_com,
  output word_t             data_in_com,
  input  word_t             data_out_com
);

  localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;

  logic [2:0]    state_q, state_d;
  addr_t         addr_q, addr_d;
  addr_t         rem_q, rem_d;
  logic [1:0]    issue_q, issue_d;
  logic          we_q, we_d;
  addr_t         acom_q, acom_d;
  word_t         dcom_q, dcom_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  word_t         fifo_head;

  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic          issue;
  logic          wr_beat;
  logic          drain_done;

  dram_com_master_rd_fifo #(
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (data_out_com),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // A read may only be issued if its word is guaranteed a FIFO slot on return.
  assign credit_sum = {1'b0, fifo_count} + (CW+1)'(inflight_count(issue_q));
  assign credit_ok  = credit_sum < (CW+1)'(RD_FIFO_DEPTH);
  assign issue      = (state_q == ST_READ) && credit_ok;
  assign wr_beat    = (state_q == ST_WRITE) && bus.wr_valid;
  assign fifo_pop   = bus.rd_ready && !fifo_empty;
  assign fifo_push  = issue_q[1] && (!fifo_full || fifo_pop);
  assign drain_done = (issue_q == 2'b00) &&
                      (fifo_empty || ((fifo_count == CW'(1)) && fifo_pop));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    we_d    = 1'b0;
    acom_d  = acom_q;
    dcom_d  = dcom_q;
    issue_d = {issue_q[0], issue};
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_base;
          rem_d  = bus.cmd_len;
          if (bus.cmd_len == '0)   state_d = ST_DONE;
          else if (bus.cmd_write)  state_d = ST_WRITE;
          else                     state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        if (wr_beat) begin
          we_d   = 1'b1;
          acom_d = addr_q;
          dcom_d = bus.wr_data;
          addr_d = addr_q + addr_t'(1);
          rem_d  = rem_q - addr_t'(1);
          if (rem_q == addr_t'(1)) state_d = ST_DONE;
        end
      end
      ST_READ: begin
        if (issue) begin
          acom_d = addr_q;
          addr_d = addr_q + addr_t'(1);
          rem_d  = rem_q - addr_t'(1);
          if (rem_q == addr_t'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      issue_q <= '0;
      we_q    <= 1'b0;
      acom_q  <= '0;
      dcom_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      issue_q <= issue_d;
      we_q    <= we_d;
      acom_q  <= acom_d;
      dcom_q  <= dcom_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.wr_ready  = (state_q == ST_WRITE);
  assign bus.rd_valid  = !fifo_empty;
  assign bus.rd_data   = fifo_empty ? '0 : fifo_head;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

  assign write_en_com  = we_q;
  assign addr_com      = acom_q;
  assign data_in_com   = dcom_q;

endmodule

// File: tb/tb_dram_com_master.sv
// Scoreboard bench for dram_com_master: randomized bursts against a 1-cycle-read DRAM model
// and a reference memory; a negedge monitor pops expected writes/reads as the DUT presents them.
module tb_dram_com_master;
  import dram_com_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        writeEnCom;
  logic [15:0] addrCom;
  logic [15:0] dataInCom;
  logic [15:0] dataOutCom;

  dram_com_master_if bus ();

  dram_com_master #(
    .RD_FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .write_en_com (writeEnCom),
    .addr_com     (addrCom),
    .data_in_com  (dataInCom),
    .data_out_com (dataOutCom)
  );

  always #5 clk = ~clk;

  logic [15:0] dram   [logic [15:0]];
  logic [15:0] refMem [logic [15:0]];

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] expWrQ[$];
  logic [15:0] expRdQ[$];
  int          weCycles[$];
  logic [15:0] weAddrs[$];
  int          popCycles[$];
  int          doneCycles[$];
  int          doneCount = 0;
  int          weCount = 0;
  logic        doneCmdReady = 1'b0;
  logic [15:0] presetWords[$];

  bit          trackIssues = 1'b0;
  logic [15:0] nextIssueAddr = '0;
  int          trackLen = 0;
  int          issued = 0;
  int          popped = 0;
  int          maxOut = 0;

  function automatic logic [15:0] seedWord(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] dramPeek(input logic [15:0] a);
    return dram.exists(a) ? dram[a] : seedWord(a);
  endfunction

  function automatic logic [15:0] refPeek(input logic [15:0] a);
    return refMem.exists(a) ? refMem[a] : seedWord(a);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // DRAM model: reads return one cycle after the address is sampled, read-before-write.
  always @(posedge clk) begin
    dataOutCom <= dramPeek(addrCom);
    if (writeEnCom) dram[addrCom] = dataInCom;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string detail);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (trackIssues && !writeEnCom && addrCom == nextIssueAddr && issued < trackLen) begin
        issued++;
        nextIssueAddr = nextIssueAddr + 16'd1;
      end
      if (trackIssues && (issued - popped) > maxOut) maxOut = issued - popped;
      if (writeEnCom) begin
        weCount++;
        weCycles.push_back(cyc);
        weAddrs.push_back(addrCom);
        if (expWrQ.size() == 0)
          failNow("dramWrite", $sformatf("write addr 0x%0h data 0x%0h, required no write", addrCom, dataInCom));
        else
          checkOutput("dramWrite", {addrCom, dataInCom}, expWrQ.pop_front());
      end
      if (bus.rd_valid && bus.rd_ready) begin
        popCycles.push_back(cyc);
        if (trackIssues) popped++;
        if (expRdQ.size() == 0)
          failNow("readData", $sformatf("popped 0x%0h, required no read word", bus.rd_data));
        else
          checkOutput("readData", {16'h0, bus.rd_data}, {16'h0, expRdQ.pop_front()});
      end
      if (bus.done) begin
        doneCount++;
        doneCycles.push_back(cyc);
        doneCmdReady = bus.cmd_ready;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit isWrite, input logic [15:0] base, input logic [15:0] len,
                               output int hsCycle);
    int waitCycles = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = isWrite;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    while (!bus.cmd_ready && waitCycles < 50) begin
      tick();
      waitCycles++;
    end
    if (!bus.cmd_ready) failNow("cmdAccept", "cmd_ready stayed 0 for 50 cycles, required 1");
    tick();
    hsCycle = cyc - 1;
    bus.cmd_valid = 1'b0;
  endtask

  // rdMode: 0 = rd_ready held high, 1 = random, 2 = low for 10 cycles then random.
  task automatic runBurst(input bit isWrite, input logic [15:0] base, input logic [15:0] len,
                          input int wrMode, input int rdMode, output int hsCycle);
    logic [15:0] words[$];
    logic [15:0] a;
    logic [15:0] w;
    int idx = 0;
    int budget = 0;
    int startDone = doneCount;
    bit beat;
    for (int i = 0; i < int'(len); i++) begin
      a = base + 16'(i);
      if (isWrite) begin
        if (presetWords.size() > 0) w = presetWords.pop_front();
        else w = 16'($urandom);
        words.push_back(w);
        expWrQ.push_back({a, w});
        refMem[a] = w;
      end else begin
        expRdQ.push_back(refPeek(a));
      end
    end
    applyStimulus(isWrite, base, len, hsCycle);
    while (doneCount == startDone && budget < 400) begin
      bus.wr_valid = isWrite && (idx < int'(len)) && (wrMode == 0 || $urandom_range(0, 2) != 0);
      bus.wr_data  = (idx < words.size()) ? words[idx] : 16'h0;
      if (rdMode == 0) bus.rd_ready = 1'b1;
      else if (rdMode == 2 && budget < 10) bus.rd_ready = 1'b0;
      else bus.rd_ready = 1'($urandom_range(0, 1));
      beat = bus.wr_valid && bus.wr_ready;
      tick();
      if (beat) idx++;
      budget++;
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    if (doneCount == startDone) failNow("burstDone", "no done pulse within 400 cycles, required one");
    checkOutput("wrQueueDrained", expWrQ.size(), 0);
    checkOutput("rdQueueDrained", expRdQ.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    int hs;
    int weBefore;
    int doneBefore;
    logic [15:0] base;
    logic [15:0] len;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    repeat (3) tick();
    checkOutput("rstCmdReady", bus.cmd_ready, 1);
    checkOutput("rstFlags", {bus.busy, bus.done, bus.rd_valid, bus.wr_ready, writeEnCom}, 0);
    checkOutput("rstDramBus", {addrCom, dataInCom}, 0);
    checkOutput("rstRdData", bus.rd_data, 0);
    rst = 1'b0;
    tick();

    $display("[TB] test 1: write burst base 0x0010 len 4");
    presetWords = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    weCycles.delete();
    doneCycles.delete();
    runBurst(1'b1, 16'h0010, 16'd4, 0, 0, hs);
    checkOutput("t1WeCount", weCycles.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput("t1WeCycle", weCycles[i] - hs, 2 + i);
    checkOutput("t1DoneCount", doneCycles.size(), 1);
    checkOutput("t1DoneCycle", doneCycles[0] - hs, 5);
    for (int i = 0; i < 4; i++) checkOutput("t1DramHolds", dramPeek(16'h0010 + 16'(i)), 32'h00A1 + i);

    $display("[TB] test 2: read burst base 0x0010 len 4");
    popCycles.delete();
    doneCycles.delete();
    runBurst(1'b0, 16'h0010, 16'd4, 0, 0, hs);
    checkOutput("t2PopCount", popCycles.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput("t2PopCycle", popCycles[i] - hs, 4 + i);
    checkOutput("t2DoneAfterPop", doneCycles[0] - popCycles[3], 1);

    $display("[TB] test 3: read len 16 with stalled consumer");
    base = 16'($urandom_range(16'h0100, 16'hEFFF));
    nextIssueAddr = base;
    issued = 0;
    popped = 0;
    maxOut = 0;
    trackLen = 16;
    trackIssues = 1'b1;
    runBurst(1'b0, base, 16'd16, 0, 2, hs);
    trackIssues = 1'b0;
    checkOutput("t3Issued", issued, 16);
    checkOutput("t3Popped", popped, 16);
    checkOutput("t3MaxOutstanding", maxOut, 4);

    $display("[TB] test 4: write burst wrapping at 0xFFFF");
    weAddrs.delete();
    runBurst(1'b1, 16'hFFFE, 16'd3, 1, 0, hs);
    checkOutput("t4AddrCount", weAddrs.size(), 3);
    checkOutput("t4Addr0", weAddrs[0], 16'hFFFE);
    checkOutput("t4Addr1", weAddrs[1], 16'hFFFF);
    checkOutput("t4Addr2", weAddrs[2], 16'h0000);

    $display("[TB] test 5: zero-length command");
    weBefore = weCount;
    doneCycles.delete();
    runBurst(1'b1, 16'h0200, 16'd0, 0, 0, hs);
    checkOutput("t5DoneCycle", doneCycles[0] - hs, 1);
    checkOutput("t5CmdReadyInDone", doneCmdReady, 0);
    checkOutput("t5ReturnCycle", cyc - hs, 2);
    checkOutput("t5CmdReadyBack", bus.cmd_ready, 1);
    checkOutput("t5NoWrites", weCount, weBefore);

    $display("[TB] test 6: reset during a write burst");
    base = 16'($urandom_range(16'h1000, 16'hE000));
    doneBefore = doneCount;
    applyStimulus(1'b1, base, 16'd8, hs);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'h1111;
    tick();
    checkOutput("t6WeBeforeReset", writeEnCom, 1);
    bus.wr_data = 16'h2222;
    rst = 1'b1;
    #1;
    checkOutput("t6WeDrop", writeEnCom, 0);
    checkOutput("t6BusyDrop", bus.busy, 0);
    tick();
    tick();
    bus.wr_valid = 1'b0;
    rst = 1'b0;
    repeat (4) tick();
    checkOutput("t6NoDone", doneCount, doneBefore);
    checkOutput("t6CmdReady", bus.cmd_ready, 1);
    checkOutput("t6NoCommit", dramPeek(base), refPeek(base));
    runBurst(1'b0, base, 16'd8, 0, 1, hs);

    $display("[TB] random write/read-back pairs");
    for (int n = 0; n < 4; n++) begin
      base = 16'($urandom);
      len  = 16'($urandom_range(1, 12));
      runBurst(1'b1, base, len, int'($urandom_range(0, 1)), 0, hs);
      runBurst(1'b0, base, len, 0, int'($urandom_range(0, 1)), hs);
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
